// File: rtl/alu_pkt_pkg.sv
// Shared types and constants for the ALU packet engine: opcodes, FSM states,
// header size and the error-response byte.
package alu_pkt_pkg;

  localparam int         HDR_BYTES = 4;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h01,
    OP_MUL  = 8'h10,
    OP_ECHO = 8'hEC
  } opcode_e;

  typedef enum logic [3:0] {
    ST_OPC,
    ST_RSV,
    ST_LENL,
    ST_LENH,
    ST_ECHO,
    ST_ACC,
    ST_DRAIN,
    ST_RES,
    ST_ERR
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_pkt_if.sv
// Byte-stream bundle between the UART side and the packet engine: RX stream in,
// TX stream out, plus busy/error status.
interface alu_pkt_if;

  logic [7:0] s_tdata_i;
  logic       s_tvalid_i;
  logic       s_tready_o;
  logic [7:0] m_tdata_o;
  logic       m_tvalid_o;
  logic       m_tready_i;
  logic       busy_o;
  logic       err_o;

  modport slave (
    input  s_tdata_i, s_tvalid_i, m_tready_i,
    output s_tready_o, m_tdata_o, m_tvalid_o, busy_o, err_o
  );

  modport master (
    output s_tdata_i, s_tvalid_i, m_tready_i,
    input  s_tready_o, m_tdata_o, m_tvalid_o, busy_o, err_o
  );

endinterface

// File: rtl/alu_pkt_ser.sv
// Byte serializer: loads a W-bit word plus a byte count and emits the bytes
// LSB first on a valid/ready stream; done_o marks the final handshake.
module alu_pkt_ser #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic [3:0]   nbytes_i,
  input  logic         ready_i,
  output logic [7:0]   data_o,
  output logic         valid_o,
  output logic         last_o,
  output logic         done_o
);

  logic [W-1:0] shift_q, shift_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;

  // The last byte is left in place after its handshake so data_o never glitches.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = nbytes_i;
      valid_d = (nbytes_i != 4'd0);
    end else if (valid_q && ready_i) begin
      if (cnt_q == 4'd1) begin
        valid_d = 1'b0;
        cnt_d   = 4'd0;
      end else begin
        shift_d = shift_q >> 8;
        cnt_d   = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = shift_q[7:0];
  assign valid_o = valid_q;
  assign last_o  = valid_q && (cnt_q == 4'd1);
  assign done_o  = valid_q && ready_i && (cnt_q == 4'd1);

endmodule

// File: rtl/alu_pkt_engine.sv
// Packet command engine: parses [op][rsv][len_lo][len_hi][payload] and answers
// ECHO/ADD/MUL. Define ALU_ERR_RESP_EN to send 0xEE after a malformed packet.
module alu_pkt_engine
  import alu_pkt_pkg::*;
#(
  parameter int OPERAND_W = 32,
  parameter int LEN_W     = 16
) (
  input logic      clk_i,
  input logic      reset_i,
  alu_pkt_if.slave bus
);

  localparam int               OP_BYTES = OPERAND_W / 8;
  localparam logic [LEN_W-1:0] HDR_LEN  = LEN_W'(HDR_BYTES);
  localparam logic [LEN_W-1:0] OP_LEN   = LEN_W'(OP_BYTES);
`ifdef ALU_ERR_RESP_EN
  localparam state_e FAIL_ST = ST_ERR;
`else
  localparam state_e FAIL_ST = ST_OPC;
`endif

  state_e               state_q, state_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [OPERAND_W-1:0] acc_q, acc_d;
  logic [OPERAND_W-1:0] word_q, word_d;
  logic [3:0]           bidx_q, bidx_d;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;

  logic                 s_tready;
  logic [LEN_W-1:0]     len_full, pay_len;
  logic                 len_short, op_alu, pkt_bad;
  logic [OPERAND_W-1:0] word_full;

  logic                 ser_load;
  logic [OPERAND_W-1:0] ser_data;
  logic [3:0]           ser_nbytes;
  logic [7:0]           ser_tdata;
  logic                 ser_tvalid, ser_last, ser_done, ser_can_load;

  alu_pkt_ser #(.W(OPERAND_W)) u_ser (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (ser_load),
    .data_i   (ser_data),
    .nbytes_i (ser_nbytes),
    .ready_i  (bus.m_tready_i),
    .data_o   (ser_tdata),
    .valid_o  (ser_tvalid),
    .last_o   (ser_last),
    .done_o   (ser_done)
  );

  // Header decode evaluated against the length MSB currently on the bus.
  always_comb begin
    len_full  = LEN_W'({bus.s_tdata_i, len_lo_q});
    pay_len   = len_full - HDR_LEN;
    len_short = (len_full < HDR_LEN);
    op_alu    = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
    pkt_bad   = len_short || !op_known(opcode_q) ||
                (op_alu && ((pay_len == '0) || ((pay_len % OP_LEN) != '0)));
    word_full = (word_q >> 8) | (OPERAND_W'(bus.s_tdata_i) << (OPERAND_W - 8));
    ser_can_load = !ser_tvalid || (bus.m_tready_i && ser_last);
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    len_lo_d   = len_lo_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    word_d     = word_q;
    bidx_d     = bidx_q;
    loaded_d   = loaded_q;
    err_d      = 1'b0;
    s_tready   = 1'b0;
    ser_load   = 1'b0;
    ser_data   = '0;
    ser_nbytes = '0;

    case (state_q)
      ST_OPC: begin
        s_tready = 1'b1;
        if (bus.s_tvalid_i) begin
          opcode_d = bus.s_tdata_i;
          state_d  = ST_RSV;
        end
      end
      ST_RSV: begin
        s_tready = 1'b1;
        if (bus.s_tvalid_i) state_d = ST_LENL;
      end
      ST_LENL: begin
        s_tready = 1'b1;
        if (bus.s_tvalid_i) begin
          len_lo_d = bus.s_tdata_i;
          state_d  = ST_LENH;
        end
      end
      ST_LENH: begin
        s_tready = 1'b1;
        if (bus.s_tvalid_i) begin
          cnt_d    = pay_len;
          bidx_d   = '0;
          word_d   = '0;
          loaded_d = 1'b0;
          acc_d    = (opcode_q == OP_MUL) ? OPERAND_W'(1) : '0;
          if (pkt_bad) begin
            err_d   = 1'b1;
            state_d = (!len_short && (pay_len != '0)) ? ST_DRAIN : FAIL_ST;
          end else if (opcode_q == OP_ECHO) begin
            state_d = (pay_len == '0) ? ST_OPC : ST_ECHO;
          end else begin
            state_d = ST_ACC;
          end
        end
      end
      ST_ECHO: begin
        s_tready = ser_can_load;
        if (bus.s_tvalid_i && ser_can_load) begin
          ser_load   = 1'b1;
          ser_data   = OPERAND_W'(bus.s_tdata_i);
          ser_nbytes = 4'd1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = ST_OPC;
        end
      end
      ST_ACC: begin
        s_tready = 1'b1;
        if (bus.s_tvalid_i) begin
          word_d = word_full;
          cnt_d  = cnt_q - 1'b1;
          if (bidx_q == 4'(OP_BYTES - 1)) begin
            bidx_d = '0;
            acc_d  = (opcode_q == OP_ADD) ? acc_q + word_full : acc_q * word_full;
          end else begin
            bidx_d = bidx_q + 4'd1;
          end
          if (cnt_q == LEN_W'(1)) state_d = ST_RES;
        end
      end
      ST_DRAIN: begin
        s_tready = 1'b1;
        if (bus.s_tvalid_i) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = FAIL_ST;
        end
      end
      // Wait for any echo byte still in flight before loading the result.
      ST_RES: begin
        if (!loaded_q && ser_can_load) begin
          ser_load   = 1'b1;
          ser_data   = acc_q;
          ser_nbytes = 4'(OP_BYTES);
          loaded_d   = 1'b1;
        end
        if (loaded_q && ser_done) begin
          loaded_d = 1'b0;
          state_d  = ST_OPC;
        end
      end
`ifdef ALU_ERR_RESP_EN
      ST_ERR: begin
        if (!loaded_q && ser_can_load) begin
          ser_load   = 1'b1;
          ser_data   = OPERAND_W'(ERR_BYTE);
          ser_nbytes = 4'd1;
          loaded_d   = 1'b1;
        end
        if (loaded_q && ser_done) begin
          loaded_d = 1'b0;
          state_d  = ST_OPC;
        end
      end
`endif
      default: state_d = ST_OPC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_OPC;
      opcode_q <= '0;
      len_lo_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      word_q   <= '0;
      bidx_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      len_lo_q <= len_lo_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      word_q   <= word_d;
      bidx_q   <= bidx_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign bus.s_tready_o = s_tready;
  assign bus.m_tdata_o  = ser_tdata;
  assign bus.m_tvalid_o = ser_tvalid;
  assign bus.busy_o     = (state_q != ST_OPC);
  assign bus.err_o      = err_q;

endmodule
